// File: rtl/haze_irq_pkg.sv
// Shared types and constants for the haze-cpu interrupt encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package haze_irq_pkg;

    localparam int IRQ_COUNT = 32;
    localparam int IRQ_ID_W  = 5;

    typedef logic [IRQ_ID_W-1:0]  irq_id_t;
    typedef logic [IRQ_COUNT-1:0] irq_vec_t;

    typedef enum logic {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } irq_state_t;

    // One-hot mask selecting a single source by ID.
    function automatic irq_vec_t id_onehot(input irq_id_t id);
        irq_vec_t v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/priority_encoder_32to5.sv
// Lowest-index-wins priority encoder, 32 request bits to a 5-bit index.
// Latency: combinational, zero cycles.
// Backpressure: none; purely a function of the input vector.
//
// Ports:
//   vec  in  32  request vector
//   idx  out 5   lowest set index (0 when nothing is set)
//   any  out 1   at least one bit of vec is set
module priority_encoder_32to5
    import haze_irq_pkg::*;
(
    input  logic [IRQ_COUNT-1:0] vec,
    output irq_id_t              idx,
    output logic                 any
);

    // Scan from the top down so the lowest set bit is the last assignment.
    always_comb begin
        idx = '0;
        any = |vec;
        for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = irq_id_t'(i);
            end
        end
    end

endmodule

// File: rtl/irq_encoder_32to5.sv
// Interrupt encoder: latches 32 request lines into a pending set and offers the lowest enabled one for claim/complete.
// Latency: a request sampled at edge k is visible on o_Valid/o_ID after edge k; all outputs registered.
// Backpressure: one interrupt in service at a time; while busy, new requests only accumulate as pending.
//
// Ports:
//   i_CLK, i_RST            clock, synchronous active-high reset
//   i_IRQ[31:0]             raw request lines (already in i_CLK domain)
//   i_Enable[31:0]          per-source enable mask
//   o_Valid, o_ID[4:0]      claimable interrupt and its ID (ID 0 when not valid)
//   i_Claim                 claim strobe, honoured only in IDLE with o_Valid=1
//   i_Complete, i_CompleteID[4:0]  completion strobe and ID, honoured only when ID matches o_ClaimedID
//   o_Busy, o_ClaimedID[4:0]       an interrupt is in service, and which one (0 when idle)
module irq_encoder_32to5
    import haze_irq_pkg::*;
#(
    parameter logic [IRQ_COUNT-1:0] EDGE_MASK = 32'h0000_0000
) (
    input  logic                 i_CLK,
    input  logic                 i_RST,
    input  logic [IRQ_COUNT-1:0] i_IRQ,
    input  logic [IRQ_COUNT-1:0] i_Enable,
    output logic                 o_Valid,
    output logic [IRQ_ID_W-1:0]  o_ID,
    input  logic                 i_Claim,
    input  logic                 i_Complete,
    input  logic [IRQ_ID_W-1:0]  i_CompleteID,
    output logic                 o_Busy,
    output logic [IRQ_ID_W-1:0]  o_ClaimedID
);

    irq_state_t    state;
    irq_vec_t      pending;
    irq_vec_t      irq_prev;

    logic          claim_acc;
    logic          complete_acc;
    irq_vec_t      level_block;
    irq_vec_t      set_vec;
    irq_vec_t      clr_vec;
    irq_vec_t      pending_nxt;
    irq_state_t    state_nxt;
    irq_id_t       enc_idx;
    logic          enc_any;

    assign claim_acc    = (state == IDLE) && o_Valid && i_Claim;
    assign complete_acc = (state == SERVICE) && i_Complete && (i_CompleteID == o_ClaimedID);

    // Gateway: a level source must not re-pend while it is in service. The
    // source being claimed on this edge counts as in service already, so a
    // level line still held high at claim time does not immediately re-pend
    // itself behind its own handler.
    always_comb begin
        level_block = '0;
        if (state == SERVICE) begin
            level_block = level_block | id_onehot(o_ClaimedID);
        end
        if (claim_acc) begin
            level_block = level_block | id_onehot(o_ID);
        end
    end

    assign set_vec = (i_IRQ & ~irq_prev & EDGE_MASK)
                   | (i_IRQ & ~EDGE_MASK & ~level_block);

    assign clr_vec = claim_acc ? id_onehot(o_ID) : '0;

    // Set has priority over the claim clear, so a fresh edge arriving on the
    // claim edge stays pending (one-deep queue behind the in-service copy).
    assign pending_nxt = (pending & ~clr_vec) | set_vec;

    always_comb begin
        state_nxt = state;
        if (claim_acc) begin
            state_nxt = SERVICE;
        end else if (complete_acc) begin
            state_nxt = IDLE;
        end
    end

    priority_encoder_32to5 u_prio (
        .vec (pending_nxt & i_Enable),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state       <= IDLE;
            pending     <= '0;
            irq_prev    <= '0;
            o_Valid     <= 1'b0;
            o_ID        <= '0;
            o_Busy      <= 1'b0;
            o_ClaimedID <= '0;
        end else begin
            state    <= state_nxt;
            pending  <= pending_nxt;
            irq_prev <= i_IRQ;
            o_Busy   <= (state_nxt == SERVICE);

            if ((state_nxt == IDLE) && enc_any) begin
                o_Valid <= 1'b1;
                o_ID    <= enc_idx;
            end else begin
                o_Valid <= 1'b0;
                o_ID    <= '0;
            end

            if (claim_acc) begin
                o_ClaimedID <= o_ID;
            end else if (complete_acc) begin
                o_ClaimedID <= '0;
            end
        end
    end

endmodule

// File: doc/irq_encoder_32to5.md
# irq_encoder_32to5

Interrupt request encoder for haze-cpu: collects 32 interrupt lines into a pending register and presents the lowest-numbered enabled pending source as a 5-bit ID. The core claims and completes that ID through a simple handshake. It sits between peripheral interrupt lines and the CPU trap/CSR logic. It is the encoding counterpart of the 5-to-32 one-hot decoder used for register select.

## Interface
- `EDGE_MASK`, default 32'h0000_0000: per-source trigger mode; bit=1 means rising-edge triggered, bit=0 means level triggered.
- `i_CLK`  in  1  clock; all logic on rising edge.
- `i_RST`  in  1  synchronous, active-high reset.
- `i_IRQ`  in  32  raw request lines, already synchronous to `i_CLK`.
- `i_Enable`  in  32  per-source enable mask.
- `o_Valid`  out  1  a claimable interrupt is presented.
- `o_ID`  out  5  index of the lowest-numbered pending and enabled source; 0 when `o_Valid`=0.
- `i_Claim`  in  1  claim strobe; accepted only on an edge where `o_Valid`=1.
- `i_Complete`  in  1  completion strobe.
- `i_CompleteID`  in  5  ID being completed.
- `o_Busy`  out  1  a claimed interrupt is in service.
- `o_ClaimedID`  out  5  ID in service; 0 when idle.

## Operation
**State and reset**
- States: IDLE and SERVICE.
- Reset clears all of the following: state=IDLE, pending P=0, previous-IRQ register=0, and every output=0.

**Setting pending bits**
- Edge source i: P[i] is set when `i_IRQ[i]`=1 and the previous sample was 0.
  - Because the previous-sample register resets to 0, a line already high when reset releases counts as an edge.
- Level source i: P[i] is set while `i_IRQ[i]`=1.
  - Exception (gateway rule): a level source is not re-pended while it is the ID in service.
- Edge sources record one edge at most. Further edges while the bit is already pending are lost.
- Each edge source can hold a pending edge while it is itself in service. The depth is 1.

**Claim**
- Accepted only in IDLE with `o_Valid`=1.
- Effects: clears P[`o_ID`], latches `o_ClaimedID`=`o_ID`, and moves to SERVICE.
- Set and claim on the same source in the same edge: set wins, so P stays 1.
- A claim while `o_Valid`=0 is ignored.

**Complete**
- Accepted only in SERVICE with `i_CompleteID`==`o_ClaimedID`.
- Effects: moves to IDLE and clears `o_ClaimedID` to 0.
- A mismatched ID, or a complete while IDLE, is ignored. There is no error flag.

**Encoding and masking**
- Encoding: the lowest index in (P & `i_Enable`) wins.
- `o_Valid` = (next state is IDLE) and at least one bit of (next P & `i_Enable`) is set.
- Masked pending bits stay pending and become visible once enabled.

## Timing
- `o_Valid`, `o_ID`, `o_Busy` and `o_ClaimedID` are registered. They reflect the state and P after the same edge.
- Latency from a request to visibility is 1 edge:
  - A line is sampled high at edge k.
  - With its enable set and the block IDLE, `o_Valid`=1 and `o_ID` are valid after edge k.
- Claim at edge k: after edge k, `o_Valid`=0, `o_Busy`=1 and `o_ClaimedID` holds the claimed ID.
- Complete at edge m: after edge m, `o_Busy`=0, and `o_Valid`/`o_ID` show any remaining pending source.
  - The next claim is therefore possible at edge m+1.
- `i_Enable` is sampled at each edge. A change affects `o_Valid`/`o_ID` after that edge.
- `i_RST` high at any edge, including mid-service, returns the block to the reset values after that edge. Pending requests are discarded.
- Claim and complete are mutually exclusive by state, so they never both take effect in one edge.

## Structure
- Package `haze_irq_pkg` holds:
  - `IRQ_COUNT`=32
  - `IRQ_ID_W`=5
  - `irq_id_t`
  - the `irq_state_t` enum {IDLE, SERVICE}
- Sub-module `priority_encoder_32to5`: combinational. Input 32-bit vector; outputs the lowest set index (5 bits) and an any-set flag.
- The top level holds P, the previous-IRQ register, the FSM and the output registers.

## Test plan
- Level sources 5 and 9 high, enable all ones → after 1 edge `o_Valid`=1, `o_ID`=5.
  - Claim → `o_Busy`=1, `o_ClaimedID`=5, `o_Valid`=0.
  - Drop line 5, then complete ID 5 → next cycle `o_Valid`=1, `o_ID`=9.
- `EDGE_MASK`[2]=1; pulse line 2, then claim ID 2. During service, pulse line 2 twice → after complete ID 2, `o_Valid`=1 with `o_ID`=2.
  - Claim and complete again → `o_Valid`=0, because only one edge was kept.
- Level line 7 high with `i_Enable`[7]=0 → `o_Valid`=0. Set `i_Enable`[7]=1 → after the next edge `o_Valid`=1, `o_ID`=7.
- In service of ID 6, drive complete with ID 4 → ignored, `o_Busy` stays 1. Then complete with ID 6 → `o_Busy`=0.
- Only line 31 high, level mode → `o_ID`=5'd31.
  - Claim with `o_Valid`=0 → no state change.
- Assert `i_RST` mid-service with lines 1 and 3 pending → after the edge all outputs are 0 and P=0.
